// File: rtl/ram_pkg.sv
// Shared types for the simple-dual-port RAM and its clear sequencer.
// Read-collision mode constants live here so the bench and RTL agree.
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every word once, writing zero, then returns idle.
// Runs after reset (optionally) or on a clear request seen while idle.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2**ADDR_W,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam state_e            RST_ST = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_ST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter parks on the last address so it never wraps mid-sequence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (clr_i) begin
                cnt_q <= '0;
            end
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        busy     = (state_q == ST_CLEAR);
        clr_we   = busy;
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/ram_sdp.sv
// Parametrised simple-dual-port RAM with registered read, valid strobe,
// selectable collision behaviour and a hardware clear sequencer.
module ram_sdp
    import ram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2**ADDR_W,
    parameter int RD_MODE    = RD_FIRST,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    output logic              busy_o,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              ren_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dvalid_o
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              wr_ok;
    logic              rd_ok;
    logic              hit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rdata;

    ram_clr_seq #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr_i),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign busy_o = busy;

    always_comb begin
        wr_ok = ({1'b0, waddr_i} < DEPTH_X);
        rd_ok = ({1'b0, raddr_i} < DEPTH_X);
        hit   = wen_i & wr_ok & (waddr_i == raddr_i);
    end

    // The clear sequencer owns the write port while it runs.
    always_comb begin
        mem_we    = wen_i & wr_ok;
        mem_waddr = waddr_i;
        mem_wdata = din_i;
        if (busy) begin
            mem_we    = clr_we;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-first falls out of the non-blocking write; write-first bypasses.
    always_comb begin
        rdata = '0;
        if (rd_ok) begin
            if ((RD_MODE == WR_FIRST) && hit) begin
                rdata = din_i;
            end else begin
                rdata = mem[raddr_i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_o   <= '0;
            dvalid_o <= 1'b0;
        end else if (ren_i && !busy) begin
            dout_o   <= rdata;
            dvalid_o <= 1'b1;
        end else begin
            dvalid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_sdp.sv
// Bench for ram_sdp: read-first, write-first and DEPTH=20 instances share
// stimulus; a memory model feeds expected reads into per-instance queues.
module tb_ram_sdp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [4:0] waddr = '0;
    logic [4:0] raddr = '0;
    logic [7:0] din = '0;

    logic       busy0, busy1, busy2;
    logic       dv0, dv1, dv2;
    logic [7:0] dout0, dout1, dout2;

    int ntot = 0;
    int npass = 0;

    logic [7:0] mdl  [32];
    logic [7:0] mdl2 [20];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    always #5 clk = ~clk;

    ram_sdp #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_MODE(0), .CLR_ON_RST(1)) u_rf (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy0),
        .wen_i(wen), .waddr_i(waddr), .din_i(din),
        .ren_i(ren), .raddr_i(raddr), .dout_o(dout0), .dvalid_o(dv0)
    );

    ram_sdp #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_MODE(1), .CLR_ON_RST(1)) u_wf (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy1),
        .wen_i(wen), .waddr_i(waddr), .din_i(din),
        .ren_i(ren), .raddr_i(raddr), .dout_o(dout1), .dvalid_o(dv1)
    );

    ram_sdp #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .RD_MODE(0), .CLR_ON_RST(1)) u_d20 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy2),
        .wen_i(wen), .waddr_i(waddr), .din_i(din),
        .ren_i(ren), .raddr_i(raddr), .dout_o(dout2), .dvalid_o(dv2)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic zero_model();
        for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
        for (int i = 0; i < 20; i++) mdl2[i] = 8'h00;
    endtask

    // Drive one idle-mode cycle; expected reads use pre-write model contents.
    task automatic step(input logic we, input logic [4:0] wa, input logic [7:0] d,
                        input logic re, input logic [4:0] ra);
        wen = we; waddr = wa; din = d; ren = re; raddr = ra;
        if (re) begin
            q0.push_back(mdl[ra]);
            q1.push_back((we && wa == ra) ? d : mdl[ra]);
            q2.push_back((ra < 5'd20) ? mdl2[ra] : 8'h00);
        end
        if (we) begin
            mdl[wa] = d;
            if (wa < 5'd20) mdl2[wa] = d;
        end
        cyc();
        wen = 1'b0; ren = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] e;
        int n, n2;
        repeat (3) @(negedge clk);
        ntot++;
        if ({busy0, busy2, dv0, dout0} !== {1'b1, 1'b1, 1'b0, 8'h00})
            $display("FAIL reset_state: got %b exp %b", {busy0, busy2, dv0, dout0}, 11'b11000000000);
        else npass++;
        rst_n = 1'b1;
        n = 0; n2 = -1;
        while (busy0 && n < 100) begin
            cyc(); n++;
            if (!busy2 && n2 < 0) n2 = n;
        end
        ntot++;
        if (n != 32 || n2 != 20) $display("FAIL reset_busy_len: got %0d/%0d exp 32/20", n, n2);
        else npass++;
        zero_model();
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'd0, 8'h00, 1'b1, 5'(i));
            e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
            ntot++;
            if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
                $display("FAIL init_read@%0d: got %h exp %h", i, {dv0, dout0, dv1, dout1, dv2, dout2}, e);
            else npass++;
        end
    endtask

    task automatic test_write_read();
        logic [26:0] e;
        step(1'b1, 5'd1, 8'h07, 1'b0, 5'd0);
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd1);
        e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
        ntot++;
        if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
            $display("FAIL write_read: got %h exp %h", {dv0, dout0, dv1, dout1, dv2, dout2}, e);
        else npass++;
        cyc();
        ntot++;
        if ({dv0, dout0, dv2, dout2} !== {1'b0, 8'h07, 1'b0, 8'h07})
            $display("FAIL read_hold: got %h exp %h", {dv0, dout0, dv2, dout2}, {1'b0, 8'h07, 1'b0, 8'h07});
        else npass++;
    endtask

    task automatic test_collision();
        logic [26:0] e;
        step(1'b1, 5'd2, 8'h05, 1'b0, 5'd0);
        step(1'b1, 5'd2, 8'hAA, 1'b1, 5'd2);
        e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
        ntot++;
        if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
            $display("FAIL collision: got %h exp %h", {dv0, dout0, dv1, dout1, dv2, dout2}, e);
        else npass++;
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd2);
        e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
        ntot++;
        if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
            $display("FAIL collision_after: got %h exp %h", {dv0, dout0, dv1, dout1, dv2, dout2}, e);
        else npass++;
    endtask

    task automatic test_back_to_back();
        logic [26:0] e;
        step(1'b1, 5'd8, 8'($urandom), 1'b0, 5'd0);
        for (int i = 9; i < 16; i++) begin
            step(1'b1, 5'(i), 8'($urandom), 1'b1, 5'(i - 1));
            e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
            ntot++;
            if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
                $display("FAIL b2b@%0d: got %h exp %h", i - 1, {dv0, dout0, dv1, dout1, dv2, dout2}, e);
            else npass++;
        end
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd15);
        e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
        ntot++;
        if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
            $display("FAIL b2b@15: got %h exp %h", {dv0, dout0, dv1, dout1, dv2, dout2}, e);
        else npass++;
    endtask

    task automatic test_clear();
        logic [26:0] e;
        int n, n2;
        logic sawdv, badhold;
        step(1'b1, 5'd3, 8'h33, 1'b0, 5'd0);
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd3);
        e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
        ntot++;
        if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
            $display("FAIL clr_pre_read: got %h exp %h", {dv0, dout0, dv1, dout1, dv2, dout2}, e);
        else npass++;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        ntot++;
        if ({busy0, busy1, busy2} !== 3'b111) $display("FAIL clr_start: got %b exp 111", {busy0, busy1, busy2});
        else npass++;
        n = 0; n2 = -1; sawdv = 1'b0; badhold = 1'b0;
        din = 8'hFF; waddr = 5'd3; raddr = 5'd3;
        while (busy0 && n < 100) begin
            wen = (n < 10); ren = (n < 10); clr = (n == 5);
            cyc(); n++;
            if (!busy2 && n2 < 0) n2 = n;
            if (dv0 || dv1 || dv2) sawdv = 1'b1;
            if (dout0 !== 8'h33 || dout2 !== 8'h33) badhold = 1'b1;
        end
        wen = 1'b0; ren = 1'b0; clr = 1'b0;
        ntot++;
        if (n != 32 || n2 != 20) $display("FAIL clr_busy_len: got %0d/%0d exp 32/20", n, n2);
        else npass++;
        ntot++;
        if ({sawdv, badhold} !== 2'b00) $display("FAIL clr_port_ignore: got dv=%b hold_bad=%b exp 0/0", sawdv, badhold);
        else npass++;
        zero_model();
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd3);
        e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
        ntot++;
        if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
            $display("FAIL clr_read@3: got %h exp %h", {dv0, dout0, dv1, dout1, dv2, dout2}, e);
        else npass++;
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd9);
        e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
        ntot++;
        if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
            $display("FAIL clr_read@9: got %h exp %h", {dv0, dout0, dv1, dout1, dv2, dout2}, e);
        else npass++;
    endtask

    task automatic test_reset_mid_clear();
        logic [26:0] e;
        int n, n2;
        step(1'b1, 5'd7, 8'h77, 1'b0, 5'd0);
        step(1'b1, 5'd31, 8'h31, 1'b1, 5'd7);
        e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
        ntot++;
        if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
            $display("FAIL rst_pre_read: got %h exp %h", {dv0, dout0, dv1, dout1, dv2, dout2}, e);
        else npass++;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (10) cyc();
        rst_n = 1'b0;
        #1;
        ntot++;
        if ({busy0, dv0, dout0} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL mid_clr_reset: got %h exp %h", {busy0, dv0, dout0}, {1'b1, 1'b0, 8'h00});
        else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; n2 = -1;
        while (busy0 && n < 100) begin
            cyc(); n++;
            if (!busy2 && n2 < 0) n2 = n;
        end
        ntot++;
        if (n != 32 || n2 != 20) $display("FAIL restart_busy_len: got %0d/%0d exp 32/20", n, n2);
        else npass++;
        zero_model();
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd31);
        e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
        ntot++;
        if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
            $display("FAIL restart_read@31: got %h exp %h", {dv0, dout0, dv1, dout1, dv2, dout2}, e);
        else npass++;
    endtask

    task automatic test_out_of_range();
        logic [26:0] e;
        step(1'b1, 5'd25, 8'h5A, 1'b0, 5'd0);
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd25);
        e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
        ntot++;
        if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
            $display("FAIL oor_read@25: got %h exp %h", {dv0, dout0, dv1, dout1, dv2, dout2}, e);
        else npass++;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 5'd0, 8'h00, 1'b1, 5'(i));
            e = {1'b1, q0.pop_front(), 1'b1, q1.pop_front(), 1'b1, q2.pop_front()};
            ntot++;
            if ({dv0, dout0, dv1, dout1, dv2, dout2} !== e)
                $display("FAIL oor_low@%0d: got %h exp %h", i, {dv0, dout0, dv1, dout1, dv2, dout2}, e);
            else npass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        test_out_of_range();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
